// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key gesture decoder: state encoding, counter width
// and bit positions of the five event outputs inside the internal event vector.
package key_pkg;

  typedef enum logic [2:0] {
    KEY_IDLE   = 3'd0,
    KEY_PRESS1 = 3'd1,
    KEY_WAIT2  = 3'd2,
    KEY_PRESS2 = 3'd3,
    KEY_LONG   = 3'd4
  } key_state_e;

  localparam int MS_CNT_W = 16;

  localparam int EV_SINGLE = 0;
  localparam int EV_DOUBLE = 1;
  localparam int EV_LONG   = 2;
  localparam int EV_REPEAT = 3;
  localparam int EV_LREL   = 4;
  localparam int EV_W      = 5;

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Millisecond timebase: a free-running cycle counter that pulses ms_tick on its
// terminal count and restarts from zero whenever the owner requests a clear.
module ms_tick_gen #(
  parameter int FREQ = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic ms_tick
);

  localparam logic [31:0] TERM = 32'(FREQ * 1000 - 1);

  logic [31:0] tick_q;
  logic [31:0] tick_d;

  always_comb begin
    ms_tick = (tick_q == TERM);
    tick_d  = tick_q + 32'd1;
    if (clr || ms_tick) begin
      tick_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into click, double click, long press, repeat and
// long release gestures; every event is a registered one-clock pulse.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int FREQ      = 60,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100,
  parameter bit PRESS_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_posedge,
  input  logic       btn_negedge,
  input  logic       btn_level,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       long_release,
  output logic [2:0] key_state
);

  localparam logic [MS_CNT_W-1:0] LONG_CNT   = MS_CNT_W'(LONG_MS);
  localparam logic [MS_CNT_W-1:0] DOUBLE_CNT = MS_CNT_W'(DOUBLE_MS);
  localparam logic [MS_CNT_W-1:0] REPEAT_CNT = MS_CNT_W'(REPEAT_MS);

  key_state_e            state_q, state_d;
  logic [MS_CNT_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [EV_W-1:0]       ev_q, ev_d;
  logic                  ms_tick;
  logic                  ms_restart;
  logic                  state_change;
  logic                  edge_clash;
  logic                  press_raw, rel_raw;
  logic                  press_pulse, rel_pulse;

  // Both edge pulses at once cannot come from a healthy debouncer, so neither is trusted.
  assign edge_clash  = btn_posedge & btn_negedge;
  assign press_raw   = PRESS_LOW ? (btn_negedge & ~btn_level) : (btn_posedge & btn_level);
  assign rel_raw     = PRESS_LOW ? (btn_posedge & btn_level) : (btn_negedge & ~btn_level);
  assign press_pulse = press_raw & ~edge_clash;
  assign rel_pulse   = rel_raw & ~edge_clash;

  assign state_change = (state_d != state_q);

  ms_tick_gen #(
    .FREQ (FREQ)
  ) u_ms_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_change),
    .ms_tick (ms_tick)
  );

  // Edges are checked before timeouts so a release/press always wins a tie.
  always_comb begin
    state_d    = state_q;
    ev_d       = '0;
    ms_restart = 1'b0;
    case (state_q)
      KEY_IDLE: begin
        if (press_pulse) begin
          state_d = KEY_PRESS1;
        end
      end
      KEY_PRESS1: begin
        if (rel_pulse) begin
          state_d = KEY_WAIT2;
        end else if (ms_cnt_q == LONG_CNT) begin
          state_d        = KEY_LONG;
          ev_d[EV_LONG]  = 1'b1;
        end
      end
      KEY_WAIT2: begin
        if (press_pulse) begin
          state_d = KEY_PRESS2;
        end else if (ms_cnt_q == DOUBLE_CNT) begin
          state_d          = KEY_IDLE;
          ev_d[EV_SINGLE]  = 1'b1;
        end
      end
      KEY_PRESS2: begin
        if (rel_pulse) begin
          state_d          = KEY_IDLE;
          ev_d[EV_DOUBLE]  = 1'b1;
        end
      end
      KEY_LONG: begin
        if (rel_pulse) begin
          state_d        = KEY_IDLE;
          ev_d[EV_LREL]  = 1'b1;
        end else if (ms_cnt_q == REPEAT_CNT) begin
          ev_d[EV_REPEAT] = 1'b1;
          ms_restart      = 1'b1;
        end
      end
      default: begin
        state_d = KEY_IDLE;
      end
    endcase
  end

  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (state_change || ms_restart) begin
      ms_cnt_d = '0;
    end else if (ms_tick && (ms_cnt_q != '1)) begin
      ms_cnt_d = ms_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= KEY_IDLE;
      ms_cnt_q <= '0;
      ev_q     <= '0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      ev_q     <= ev_d;
    end
  end

  assign single_click = ev_q[EV_SINGLE];
  assign double_click = ev_q[EV_DOUBLE];
  assign long_press   = ev_q[EV_LONG];
  assign repeat_evt   = ev_q[EV_REPEAT];
  assign long_release = ev_q[EV_LREL];
  assign key_state    = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: a timestamp-based gesture model predicts event pulses, a
// monitor compares every DUT pulse and the state code against the predictions.
module tb_key_event_decoder;
  import key_pkg::*;

  localparam int FREQ      = 1;
  localparam int LONG_MS   = 10;
  localparam int DOUBLE_MS = 5;
  localparam int REPEAT_MS = 3;
  localparam int N         = FREQ * 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_posedge = 1'b0;
  logic       btn_negedge = 1'b0;
  logic       btn_level = 1'b1;
  logic       single_click, double_click, long_press, repeat_evt, long_release;
  logic [2:0] key_state;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    seen[EV_W];
  int    snap_seen[EV_W];
  int    last_cyc[EV_W];
  int    m_phase = 0;
  int    m_since = 0;
  int    m_next_rep = 0;
  string ev_name[EV_W] = '{"single_click", "double_click", "long_press", "repeat_evt", "long_release"};

  key_event_decoder #(
    .FREQ      (FREQ),
    .LONG_MS   (LONG_MS),
    .DOUBLE_MS (DOUBLE_MS),
    .REPEAT_MS (REPEAT_MS),
    .PRESS_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_posedge  (btn_posedge),
    .btn_negedge  (btn_negedge),
    .btn_level    (btn_level),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_evt   (repeat_evt),
    .long_release (long_release),
    .key_state    (key_state)
  );

  always #5 clk = ~clk;

  // Reference model: phases plus timestamps; deadlines are derived from elapsed clock edges.
  initial begin
    logic prs, rls;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      prs = btn_negedge & ~btn_level & ~btn_posedge;
      rls = btn_posedge & btn_level & ~btn_negedge;
      if (!rst) begin
        m_phase = 0;
        exp_q.delete();
      end else begin
        case (m_phase)
          0: if (prs) begin m_phase = 1; m_since = cyc; end
          1: begin
            if (rls) begin
              m_phase = 2; m_since = cyc;
            end else if (cyc == m_since + LONG_MS * N + 1) begin
              exp_q.push_back('{EV_LONG, cyc});
              m_phase = 4; m_since = cyc;
              m_next_rep = cyc + REPEAT_MS * N + 1;
            end
          end
          2: begin
            if (prs) begin
              m_phase = 3; m_since = cyc;
            end else if (cyc == m_since + DOUBLE_MS * N + 1) begin
              exp_q.push_back('{EV_SINGLE, cyc});
              m_phase = 0;
            end
          end
          3: if (rls) begin exp_q.push_back('{EV_DOUBLE, cyc}); m_phase = 0; end
          4: begin
            if (rls) begin
              exp_q.push_back('{EV_LREL, cyc});
              m_phase = 0;
            end else if (cyc == m_next_rep) begin
              exp_q.push_back('{EV_REPEAT, cyc});
              m_next_rep = m_next_rep + REPEAT_MS * N;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every event pulse.
  initial begin
    logic [EV_W-1:0] ev;
    int   k;
    exp_t e;
    forever begin
      @(negedge clk);
      ev = {long_release, repeat_evt, long_press, double_click, single_click};
      total++;
      if (!rst) begin
        if (ev != '0 || key_state != 3'd0) begin
          bad++;
          $display("FAIL reset_outputs: events=%b key_state=%0d, required events=00000 key_state=0", ev, key_state);
        end
      end else begin
        if (int'(key_state) != m_phase) begin
          bad++;
          $display("FAIL key_state @cyc %0d: got %0d, required %0d", cyc, key_state, m_phase);
        end
        total++;
        if ($countones(ev) > 1) begin
          bad++;
          $display("FAIL one_hot @cyc %0d: events=%b, required at most one bit", cyc, ev);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_event: %s expected @cyc %0d, not seen (now %0d)", ev_name[e.kind], e.cyc, cyc);
        end
        if (ev != '0) begin
          k = 0;
          for (int i = EV_W - 1; i >= 0; i--) if (ev[i]) k = i;
          seen[k]++;
          last_cyc[k] = cyc;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s @cyc %0d, required none", ev_name[k], cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
              bad++;
              $display("FAIL event_match: got %s @cyc %0d, required %s @cyc %0d",
                       ev_name[k], cyc, ev_name[e.kind], e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached before end of stimulus, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_delta(input string name, input int k, input int req);
    check_int(name, seen[k] - snap_seen[k], req);
  endtask

  task automatic snap();
    snap_seen = seen;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Pulse tasks return on the falling edge whose cyc equals the sampling edge.
  task automatic do_press();
    @(negedge clk);
    btn_level   = 1'b0;
    btn_negedge = 1'b1;
    @(negedge clk);
    btn_negedge = 1'b0;
  endtask

  task automatic do_release();
    @(negedge clk);
    btn_level   = 1'b1;
    btn_posedge = 1'b1;
    @(negedge clk);
    btn_posedge = 1'b0;
  endtask

  task automatic press_at(input int x);
    wait_until(x - 2);
    do_press();
  endtask

  task automatic rel_at(input int x);
    wait_until(x - 2);
    do_release();
  endtask

  initial begin
    int p, r, p2;
    for (int i = 0; i < EV_W; i++) begin
      seen[i] = 0;
      last_cyc[i] = -1;
    end
    #1;
    check_int("reset_key_state", int'(key_state), 0);
    check_int("reset_events", int'({long_release, repeat_evt, long_press, double_click, single_click}), 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(20);

    // single click
    snap();
    do_press(); p = cyc;
    rel_at(p + 4 * N + int'($urandom_range(0, 200))); r = cyc;
    wait_cyc(DOUBLE_MS * N + 10);
    check_delta("single_count", EV_SINGLE, 1);
    check_int("single_time", last_cyc[EV_SINGLE], r + DOUBLE_MS * N + 1);
    check_delta("single_no_double", EV_DOUBLE, 0);
    check_delta("single_no_long", EV_LONG, 0);

    // double click
    snap();
    do_press(); p = cyc;
    rel_at(p + 2 * N + int'($urandom_range(0, 200))); r = cyc;
    press_at(r + 3 * N + int'($urandom_range(0, 200))); p2 = cyc;
    rel_at(p2 + 2 * N + int'($urandom_range(0, 200))); r = cyc;
    wait_cyc(DOUBLE_MS * N + 10);
    check_delta("double_count", EV_DOUBLE, 1);
    check_int("double_time", last_cyc[EV_DOUBLE], r);
    check_delta("double_no_single", EV_SINGLE, 0);

    // long press with repeats
    snap();
    do_press(); p = cyc;
    rel_at(p + 20 * N); r = cyc;
    wait_cyc(10);
    check_delta("long_count", EV_LONG, 1);
    check_int("long_time", last_cyc[EV_LONG], p + LONG_MS * N + 1);
    check_delta("repeat_count", EV_REPEAT, 3);
    check_int("repeat_last_time", last_cyc[EV_REPEAT], p + LONG_MS * N + 1 + 3 * REPEAT_MS * N + 1);
    check_delta("lrel_count", EV_LREL, 1);
    check_int("lrel_time", last_cyc[EV_LREL], r);

    // release exactly as the long timeout expires
    snap();
    do_press(); p = cyc;
    rel_at(p + LONG_MS * N + 1); r = cyc;
    wait_cyc(DOUBLE_MS * N + 10);
    check_delta("tie_no_long", EV_LONG, 0);
    check_delta("tie_single", EV_SINGLE, 1);
    check_int("tie_single_time", last_cyc[EV_SINGLE], r + DOUBLE_MS * N + 1);

    // reset while in long hold, key kept pressed across reset
    snap();
    do_press(); p = cyc;
    wait_until(p + 12 * N);
    #3 rst = 1'b0;
    #1;
    check_int("async_rst_state", int'(key_state), 0);
    check_int("async_rst_events", int'({long_release, repeat_evt, long_press, double_click, single_click}), 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(100);
    do_release();
    wait_cyc(N);
    check_delta("rst_long_before", EV_LONG, 1);
    check_delta("rst_no_lrel", EV_LREL, 0);
    check_delta("rst_no_single", EV_SINGLE, 0);

    // both edge pulses together in IDLE and PRESS1
    snap();
    @(negedge clk);
    btn_negedge = 1'b1; btn_posedge = 1'b1; btn_level = 1'b0;
    @(negedge clk);
    btn_negedge = 1'b0; btn_posedge = 1'b0; btn_level = 1'b1;
    wait_cyc(5);
    check_int("clash_idle_state", int'(key_state), 0);
    do_press();
    wait_cyc(20);
    @(negedge clk);
    btn_negedge = 1'b1; btn_posedge = 1'b1; btn_level = 1'b1;
    @(negedge clk);
    btn_negedge = 1'b0; btn_posedge = 1'b0; btn_level = 1'b0;
    wait_cyc(5);
    check_int("clash_press1_state", int'(key_state), 1);
    rel_at(cyc + 100); r = cyc;
    press_at(r + 200);
    rel_at(cyc + 100);
    wait_cyc(10);
    check_delta("clash_double", EV_DOUBLE, 1);
    check_delta("clash_no_single", EV_SINGLE, 0);

    // random short gestures, judged by the scoreboard alone
    for (int i = 0; i < 2; i++) begin
      do_press();
      rel_at(cyc + int'($urandom_range(50, N / 2)));
      wait_cyc(int'($urandom_range(50, 2 * N)));
    end
    wait_cyc(DOUBLE_MS * N + 10);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
